// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register controller.
//   - Command mode encodings (hold / shift right / shift left / parallel load).
//   - FSM state type for the command sequencer.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/four_to_one_multiplexer.sv
// Single-bit 4:1 multiplexer feeding one register cell.
// Ports:
//   i_in0..i_in3 : data inputs (hold / from-left / from-right / load)
//   i_sel0       : select MSB
//   i_sel1       : select LSB
//   o_out        : selected input, index {i_sel0, i_sel1}
module four_to_one_multiplexer (
    input  logic i_in0,
    input  logic i_in1,
    input  logic i_in2,
    input  logic i_in3,
    input  logic i_sel0,
    input  logic i_sel1,
    output logic o_out
);

    always_comb begin
        o_out = i_in0;
        case ({i_sel0, i_sel1})
            2'b00:   o_out = i_in0;
            2'b01:   o_out = i_in1;
            2'b10:   o_out = i_in2;
            default: o_out = i_in3;
        endcase
    end

endmodule

// File: rtl/universal_shift_register_ctrl.sv
// Command-driven universal shift register.
// A {mode, count} command is accepted over cmd_valid/cmd_ready; the FSM then
// applies the mode to every cell for exactly count clock edges and pulses done.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE)
//   cmd_mode, cmd_count  : operation and number of edges to apply
//   par_in               : load data, captured at handshake
//   ser_in_r, ser_in_l   : serial fill bits, sampled live on each shift edge
//   q                    : register contents
//   ser_out_r, ser_out_l : q[0], q[WIDTH-1]
//   busy, done           : RUN state, one-cycle completion pulse
module universal_shift_register_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_remaining;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_par_hold;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_mux_out;
    logic [1:0]         w_sel;
    logic               w_handshake;

    assign w_handshake = cmd_valid && (r_state == ST_IDLE);

    // Outside RUN the muxes are forced to hold so q only moves on op edges.
    assign w_sel = (r_state == ST_RUN) ? r_mode : MODE_HOLD;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    w_state_nxt = (cmd_count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (r_remaining == CNT_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_mode      <= MODE_HOLD;
            r_par_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_handshake) begin
                r_mode      <= cmd_mode;
                r_remaining <= cmd_count;
                r_par_hold  <= par_in;
            end else if (r_state == ST_RUN) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // Cell i: in1 takes the bit from the left neighbour (shift right),
    // in2 from the right neighbour (shift left); edge cells take serial inputs.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic w_from_hi;
        logic w_from_lo;

        if (gi == WIDTH - 1) begin : g_top
            assign w_from_hi = ser_in_r;
        end else begin : g_top
            assign w_from_hi = r_q[gi+1];
        end

        if (gi == 0) begin : g_bot
            assign w_from_lo = ser_in_l;
        end else begin : g_bot
            assign w_from_lo = r_q[gi-1];
        end

        four_to_one_multiplexer u_mux (
            .i_in0  (r_q[gi]),
            .i_in1  (w_from_hi),
            .i_in2  (w_from_lo),
            .i_in3  (r_par_hold[gi]),
            .i_sel0 (w_sel[1]),
            .i_sel1 (w_sel[0]),
            .o_out  (w_mux_out[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_mux_out;
        end
    end

    assign q         = r_q;
    assign ser_out_r = r_q[0];
    assign ser_out_l = r_q[WIDTH-1];
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule
